// File: rtl/poly_op_sched.sv
// Command scheduler for a polynomial accelerator: queues {opcode, sub, vlen}
// commands, launches one engine at a time and arbitrates the shared RAM.
module poly_op_sched #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_opcode,
  input  logic        cmd_sub,
  input  logic [3:0]  cmd_vlen,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  output logic        eng_add_sub_sel,
  output logic [3:0]  eng_vector_length,
  output logic [1:0]  ram_sel,
  output logic        busy,
  output logic        op_done,
  output logic        op_error,
  output logic [1:0]  err_code,
  output logic [15:0] ops_count
);

  localparam int unsigned AW       = $clog2(CMD_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(CMD_DEPTH);
  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [6:0]    q_mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   q_count, q_count_nxt;
  logic          push, pop, q_empty, q_full;
  logic [1:0]    head_op;
  logic          head_sub;
  logic [3:0]    head_vlen;
  logic [1:0]    op_q;
  logic [11:0]   tmo_cnt;
  logic          done_hit;
  logic          err_load;
  logic [1:0]    err_val;

  assign q_empty   = (q_count == '0);
  assign q_full    = (q_count == FULL_CNT);
  assign push      = cmd_valid && cmd_ready && !q_full;
  assign pop       = (state == IDLE) && !q_empty;
  assign head_op   = q_mem[rd_ptr][6:5];
  assign head_sub  = q_mem[rd_ptr][4];
  assign head_vlen = q_mem[rd_ptr][3:0];

  always_comb begin
    q_count_nxt = q_count;
    case ({push, pop})
      2'b10:   q_count_nxt = q_count + (AW+1)'(1);
      2'b01:   q_count_nxt = q_count - (AW+1)'(1);
      default: q_count_nxt = q_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {cmd_opcode, cmd_sub, cmd_vlen};
  end

  always_comb begin
    done_hit = 1'b0;
    case (op_q)
      2'd0:    done_hit = eng_done[0];
      2'd1:    done_hit = eng_done[1];
      2'd2:    done_hit = eng_done[2];
      default: done_hit = 1'b0;
    endcase
  end

  // Validation happens on the popped head in the same cycle it is latched.
  always_comb begin
    state_nxt = state;
    err_load  = 1'b0;
    err_val   = err_code;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          if (head_op == 2'b11) begin
            state_nxt = ERR;
            err_load  = 1'b1;
            err_val   = 2'b01;
          end else if (head_vlen == 4'd0 || head_vlen > 4'd8) begin
            state_nxt = ERR;
            err_load  = 1'b1;
            err_val   = 2'b10;
          end else begin
            state_nxt = LAUNCH;
          end
        end
      end
      LAUNCH: state_nxt = BUSY;
      BUSY: begin
        if (done_hit) begin
          state_nxt = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERR;
          err_load  = 1'b1;
          err_val   = 2'b11;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      q_count           <= '0;
      cmd_ready         <= 1'b0;
      op_q              <= 2'b11;
      eng_add_sub_sel   <= 1'b0;
      eng_vector_length <= '0;
      err_code          <= '0;
      tmo_cnt           <= '0;
      ops_count         <= '0;
    end else begin
      state     <= state_nxt;
      q_count   <= q_count_nxt;
      cmd_ready <= (q_count_nxt != FULL_CNT);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr            <= rd_ptr + AW'(1);
        op_q              <= head_op;
        eng_add_sub_sel   <= head_sub;
        eng_vector_length <= head_vlen;
      end
      if (err_load) err_code <= err_val;
      if (state == LAUNCH)    tmo_cnt <= '0;
      else if (state == BUSY) tmo_cnt <= tmo_cnt + 12'd1;
      if (state == DONE) ops_count <= ops_count + 16'd1;
    end
  end

  always_comb begin
    eng_start = '0;
    if (state == LAUNCH) begin
      case (op_q)
        2'd0:    eng_start = 3'b001;
        2'd1:    eng_start = 3'b010;
        2'd2:    eng_start = 3'b100;
        default: eng_start = '0;
      endcase
    end
  end

  assign ram_sel  = (state == LAUNCH || state == BUSY) ? op_q : 2'b11;
  assign busy     = (state == LAUNCH) || (state == BUSY) || (state == DONE);
  assign op_done  = (state == DONE);
  assign op_error = (state == ERR);

endmodule

// File: tb/tb_poly_op_sched.sv
// Directed bench for poly_op_sched: latency, queue overflow, validation errors,
// timeout/done race, counter wrap and asynchronous reset.
module tb_poly_op_sched;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode = '0;
  logic        cmd_sub = 1'b0;
  logic [3:0]  cmd_vlen = '0;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done = '0;
  logic        eng_add_sub_sel;
  logic [3:0]  eng_vector_length;
  logic [1:0]  ram_sel;
  logic        busy;
  logic        op_done;
  logic        op_error;
  logic [1:0]  err_code;
  logic [15:0] ops_count;

  int vecs = 0;
  int errs = 0;
  int exp_ops = 0;

  poly_op_sched #(.CMD_DEPTH(4), .TIMEOUT(4095)) dut (
    .clk(clk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_sub(cmd_sub), .cmd_vlen(cmd_vlen),
    .eng_start(eng_start), .eng_done(eng_done), .eng_add_sub_sel(eng_add_sub_sel),
    .eng_vector_length(eng_vector_length), .ram_sel(ram_sel), .busy(busy),
    .op_done(op_done), .op_error(op_error), .err_code(err_code), .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] op, input logic s, input logic [3:0] v);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_sub = s; cmd_vlen = v;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for a launch, then checks the launched command's fields.
  task automatic wait_launch(input string tag, input logic [2:0] es, input logic [3:0] ev,
                             input logic esub, input logic [1:0] esel);
    for (int k = 0; k < 20; k++) begin
      if (eng_start != 3'b000) break;
      tick();
    end
    chk({tag, "_start"}, 32'(eng_start), 32'(es));
    chk({tag, "_vlen"},  32'(eng_vector_length), 32'(ev));
    chk({tag, "_sub"},   32'(eng_add_sub_sel), 32'(esub));
    chk({tag, "_sel"},   32'(ram_sel), 32'(esel));
  endtask

  // From a LAUNCH cycle: one BUSY cycle, then done from engine op.
  task automatic finish_cmd(input string tag, input logic [1:0] op);
    tick();
    eng_done = 3'b001 << op;
    tick();
    eng_done = '0;
    chk({tag, "_opdone"}, 32'(op_done), 32'd1);
    exp_ops = (exp_ops + 1) % 65536;
    tick();
    chk({tag, "_count"}, 32'(ops_count), 32'(exp_ops));
  endtask

  initial begin
    logic [6:0] cmds [5];
    int n;
    logic seen;

    // reset values
    repeat (2) tick();
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_sel", 32'(ram_sel), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_flags", 32'({op_done, op_error}), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_count", 32'(ops_count), 32'd0);
    areset = 1'b0;
    chk("rel_ready0", 32'(cmd_ready), 32'd0);
    tick();
    chk("rel_ready1", 32'(cmd_ready), 32'd1);

    // add, vlen=4, sub=1: launch two edges after accept
    push(2'd0, 1'b1, 4'd4);
    chk("add_pop_start", 32'(eng_start), 32'd0);
    chk("add_pop_busy", 32'(busy), 32'd0);
    tick();
    chk("add_start", 32'(eng_start), 32'b001);
    chk("add_vlen", 32'(eng_vector_length), 32'd4);
    chk("add_sub", 32'(eng_add_sub_sel), 32'd1);
    chk("add_sel", 32'(ram_sel), 32'd0);
    chk("add_busy", 32'(busy), 32'd1);
    tick();
    chk("add_start_pulse", 32'(eng_start), 32'd0);
    repeat (298) tick();
    chk("add_sel_stable", 32'(ram_sel), 32'd0);
    eng_done = 3'b001;
    tick();
    eng_done = '0;
    chk("add_opdone", 32'(op_done), 32'd1);
    chk("add_done_sel", 32'(ram_sel), 32'd3);
    chk("add_done_busy", 32'(busy), 32'd1);
    tick();
    exp_ops = 1;
    chk("add_opdone_pulse", 32'(op_done), 32'd0);
    chk("add_count", 32'(ops_count), 32'(exp_ops));
    chk("add_idle_busy", 32'(busy), 32'd0);

    // illegal opcode beats illegal vlen; then bad vlen on NTT
    push(2'd3, 1'b0, 4'd0);
    chk("bad_op_pre", 32'(op_error), 32'd0);
    tick();
    chk("bad_op_err", 32'(op_error), 32'd1);
    chk("bad_op_code", 32'(err_code), 32'd1);
    chk("bad_op_start", 32'(eng_start), 32'd0);
    chk("bad_op_busy", 32'(busy), 32'd0);
    tick();
    chk("bad_op_pulse", 32'(op_error), 32'd0);
    chk("bad_op_hold", 32'(err_code), 32'd1);
    push(2'd1, 1'b0, 4'd9);
    tick();
    chk("bad_vlen_err", 32'(op_error), 32'd1);
    chk("bad_vlen_code", 32'(err_code), 32'd2);
    chk("bad_vlen_start", 32'(eng_start), 32'd0);
    tick();

    // overflow: one in flight, five offered, fifth dropped
    push(2'd0, 1'b0, 4'd5);
    tick();
    chk("ovf_launch", 32'(eng_start), 32'b001);
    tick();
    cmds[0] = {2'd1, 1'b0, 4'd1};
    cmds[1] = {2'd2, 1'b0, 4'd2};
    cmds[2] = {2'd0, 1'b1, 4'd3};
    cmds[3] = {2'd1, 1'b1, 4'd8};
    cmds[4] = {2'd2, 1'b0, 4'd7};
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      {cmd_opcode, cmd_sub, cmd_vlen} = cmds[i];
      tick();
      chk($sformatf("ovf_ready%0d", i), 32'(cmd_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    cmd_valid = 1'b0;
    chk("ovf_inflight_busy", 32'(busy), 32'd1);
    eng_done = 3'b001;
    tick();
    eng_done = '0;
    chk("ovf_inflight_done", 32'(op_done), 32'd1);
    exp_ops++;
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_launch($sformatf("ovf_q%0d", i), 3'b001 << cmds[i][6:5], cmds[i][3:0],
                  cmds[i][4], cmds[i][6:5]);
      finish_cmd($sformatf("ovf_q%0d", i), cmds[i][6:5]);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eng_start != 3'b000) seen = 1'b1;
    end
    chk("ovf_dropped", 32'(seen), 32'd0);
    chk("ovf_count", 32'(ops_count), 32'd6);

    // PWM timeout; done during LAUNCH and from other engines ignored
    push(2'd2, 1'b0, 4'd4);
    wait_launch("tmo", 3'b100, 4'd4, 1'b0, 2'd2);
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      eng_done = (k == 0) ? 3'b100 : (k == 5) ? 3'b011 : 3'b000;
      tick();
      if (op_error || op_done) break;
      if (busy) n++;
    end
    eng_done = '0;
    chk("tmo_busy_cycles", 32'(n), 32'd4095);
    chk("tmo_err", 32'(op_error), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd3);
    chk("tmo_count", 32'(ops_count), 32'(exp_ops));
    tick();

    // done on the last BUSY cycle wins over timeout
    push(2'd2, 1'b1, 4'd3);
    wait_launch("race", 3'b100, 4'd3, 1'b1, 2'd2);
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      eng_done = (n == 4095) ? 3'b100 : 3'b000;
      tick();
      if (op_error || op_done) break;
      n++;
    end
    eng_done = '0;
    chk("race_busy_cycles", 32'(n), 32'd4095);
    chk("race_done", 32'(op_done), 32'd1);
    chk("race_noerr", 32'(op_error), 32'd0);
    exp_ops++;
    tick();
    chk("race_count", 32'(ops_count), 32'(exp_ops));

    // ops_count wrap
    force dut.ops_count = 16'hffff;
    tick();
    release dut.ops_count;
    exp_ops = 65535;
    chk("wrap_pre", 32'(ops_count), 32'hffff);
    push(2'd1, 1'b0, 4'd2);
    wait_launch("wrap", 3'b010, 4'd2, 1'b0, 2'd1);
    finish_cmd("wrap", 2'd1);

    // async reset during BUSY with two queued
    push(2'd0, 1'b0, 4'd6);
    wait_launch("arst", 3'b001, 4'd6, 1'b0, 2'd0);
    tick();
    push(2'd1, 1'b0, 4'd3);
    push(2'd2, 1'b0, 4'd5);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #2 areset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sel", 32'(ram_sel), 32'd3);
    chk("arst_ready", 32'(cmd_ready), 32'd0);
    chk("arst_count", 32'(ops_count), 32'd0);
    chk("arst_err", 32'(err_code), 32'd0);
    chk("arst_flags", 32'({op_done, op_error, eng_start}), 32'd0);
    tick();
    areset = 1'b0;
    tick();
    chk("arst_ready1", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (eng_start != 3'b000 || op_done || op_error || busy) seen = 1'b1;
      tick();
    end
    chk("arst_flushed", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
